// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state type and counter-width helper for the reset sequencer
// Contents: reset_seq_state_t (ASSERT, RELEASE, DONE), cnt_width(x) = $clog2(x+1)
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        DONE
    } reset_seq_state_t;

    function automatic int cnt_width(input int x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: software request and sequenced reset outputs of the reset sequencer
// Signals: SW_RST_REQ (re-run request), STAGE_RSTN[NUM_STAGES] (active-low resets),
//          RST_DONE (all stages released), BUSY (sequence in progress)
// Modports: master = sequencer side, slave = consumer/controller side
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
) ();
    logic                  SW_RST_REQ;
    logic [NUM_STAGES-1:0] STAGE_RSTN;
    logic                  RST_DONE;
    logic                  BUSY;

    modport master (input SW_RST_REQ, output STAGE_RSTN, output RST_DONE, output BUSY);
    modport slave (output SW_RST_REQ, input STAGE_RSTN, input RST_DONE, input BUSY);
endinterface

// File: rtl/sync_reset.sv
// sync_reset: 2-flop synchroniser, asserts asynchronously and releases synchronously
// Ports: CLK (clock), ARSTN (async active-low reset in), srstn (synchronised active-low reset out)
module sync_reset (
    input  logic CLK,
    input  logic ARSTN,
    output logic srstn
);
    logic meta;

    always_ff @(posedge CLK or negedge ARSTN)
        if (!ARSTN) {srstn, meta} <= 2'b00;
        else        {srstn, meta} <= {meta, 1'b1};
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds NUM_STAGES reset domains, then releases them in order with fixed spacing
// Ports: CLK (clock), ARSTN (async active-low board reset),
//        bus.SW_RST_REQ (sync re-sequence request), bus.STAGE_RSTN (per-domain resets, bit 0 first),
//        bus.RST_DONE (all released), bus.BUSY (= !RST_DONE)
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGE_DELAY = 16
) (
    input  logic                      CLK,
    input  logic                      ARSTN,
    reset_sequencer_if.master         bus
);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int DW = cnt_width(STAGE_DELAY);
    localparam int IW = cnt_width(NUM_STAGES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DLY_LAST   = DW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0] LAST_STAGE = IW'(NUM_STAGES - 1);

    if (NUM_STAGES < 1) begin : g_bad_stages
        $error("reset_sequencer: NUM_STAGES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_DELAY < 1) begin : g_bad_delay
        $error("reset_sequencer: STAGE_DELAY must be >= 1");
    end

    logic                  srstn;
    reset_seq_state_t      state;
    logic [HW-1:0]         hold_cnt;
    logic [DW-1:0]         dly_cnt;
    logic [IW-1:0]         stage_idx;
    logic [NUM_STAGES-1:0] stage_rstn;
    logic                  rst_done;
    logic                  busy;

    sync_reset u_sync (
        .CLK   (CLK),
        .ARSTN (ARSTN),
        .srstn (srstn)
    );

    // Released stages form a prefix of ones; shifting in a 1 releases the next
    // stage and keeps the ordering monotonic by construction.
    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            state      <= ASSERT;
            hold_cnt   <= '0;
            dly_cnt    <= '0;
            stage_idx  <= '0;
            stage_rstn <= '0;
            rst_done   <= 1'b0;
            busy       <= 1'b1;
        end else if (srstn) begin
            if (bus.SW_RST_REQ) begin
                state      <= ASSERT;
                hold_cnt   <= '0;
                dly_cnt    <= '0;
                stage_idx  <= '0;
                stage_rstn <= '0;
                rst_done   <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    ASSERT:
                        if (hold_cnt == HOLD_LAST) begin
                            stage_rstn <= NUM_STAGES'(1);
                            stage_idx  <= '0;
                            dly_cnt    <= '0;
                            state      <= RELEASE;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    RELEASE:
                        if (stage_idx == LAST_STAGE) begin
                            state    <= DONE;
                            rst_done <= 1'b1;
                            busy     <= 1'b0;
                        end else if (dly_cnt == DLY_LAST) begin
                            stage_rstn <= (stage_rstn << 1) | NUM_STAGES'(1);
                            stage_idx  <= stage_idx + IW'(1);
                            dly_cnt    <= '0;
                        end else begin
                            dly_cnt <= dly_cnt + DW'(1);
                        end
                    default: ;
                endcase
            end
        end
    end

    assign bus.STAGE_RSTN = stage_rstn;
    assign bus.RST_DONE   = rst_done;
    assign bus.BUSY       = busy;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of release ordering, ARSTN abort and software re-sequence
module tb_reset_sequencer;
    logic CLK = 1'b0;
    logic ARSTN = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reset_sequencer_if #(.NUM_STAGES(4)) bus0 ();
    reset_sequencer_if #(.NUM_STAGES(1)) bus1 ();

    assign bus1.SW_RST_REQ = 1'b0;

    reset_sequencer #(.NUM_STAGES(4), .HOLD_CYCLES(8), .STAGE_DELAY(16)) dut0 (
        .CLK   (CLK),
        .ARSTN (ARSTN),
        .bus   (bus0.master)
    );

    reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_DELAY(1)) dut1 (
        .CLK   (CLK),
        .ARSTN (ARSTN),
        .bus   (bus1.master)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk0(input string tag, input logic [3:0] s, input logic d);
        chk({tag, "_stage"}, 32'(bus0.STAGE_RSTN), 32'(s));
        chk({tag, "_done"}, 32'(bus0.RST_DONE), 32'(d));
        chk({tag, "_busy"}, 32'(bus0.BUSY), 32'(!d));
    endtask

    // Called just before E1 (first rising edge with ARSTN high).
    task automatic run_seq(input string tag);
        tick(2);
        chk0({tag, "_e2"}, 4'b0000, 1'b0);
        chk({tag, "_n1_e2"}, 32'(bus1.STAGE_RSTN), 32'd0);
        tick(1);
        chk({tag, "_n1_e3_stage"}, 32'(bus1.STAGE_RSTN), 32'd1);
        chk({tag, "_n1_e3_done"}, 32'(bus1.RST_DONE), 32'd0);
        tick(1);
        chk({tag, "_n1_e4_done"}, 32'(bus1.RST_DONE), 32'd1);
        chk({tag, "_n1_e4_busy"}, 32'(bus1.BUSY), 32'd0);
        tick(5);
        chk0({tag, "_e9"}, 4'b0000, 1'b0);
        tick(1);
        chk0({tag, "_e10"}, 4'b0001, 1'b0);
        tick(15);
        chk0({tag, "_e25"}, 4'b0001, 1'b0);
        tick(1);
        chk0({tag, "_e26"}, 4'b0011, 1'b0);
        tick(15);
        chk0({tag, "_e41"}, 4'b0011, 1'b0);
        tick(1);
        chk0({tag, "_e42"}, 4'b0111, 1'b0);
        tick(16);
        chk0({tag, "_e58"}, 4'b1111, 1'b0);
        tick(1);
        chk0({tag, "_e59"}, 4'b1111, 1'b1);
    endtask

    // Invariants on both instances: released bits form a prefix, BUSY mirrors RST_DONE.
    always @(negedge CLK) begin
        chk("mono0", 32'((bus0.STAGE_RSTN >> 1) & ~bus0.STAGE_RSTN), 32'd0);
        chk("busy0", 32'(bus0.BUSY), 32'(!bus0.RST_DONE));
        chk("busy1", 32'(bus1.BUSY), 32'(!bus1.RST_DONE));
    end

    initial begin
        bus0.SW_RST_REQ = 1'b0;
        #1 ARSTN = 1'b0;
        #2;
        chk0("por_low", 4'b0000, 1'b0);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        ARSTN = 1'b1;
        run_seq("por");

        tick(3);
        chk0("done_idle", 4'b1111, 1'b1);
        bus0.SW_RST_REQ = 1'b1;
        tick(1);
        chk0("sw1_sample", 4'b0000, 1'b0);
        bus0.SW_RST_REQ = 1'b0;
        tick(7);
        chk0("sw1_hold", 4'b0000, 1'b0);
        tick(1);
        chk0("sw1_rel0", 4'b0001, 1'b0);
        tick(48);
        chk0("sw1_rel3", 4'b1111, 1'b0);
        tick(1);
        chk0("sw1_done", 4'b1111, 1'b1);

        bus0.SW_RST_REQ = 1'b1;
        tick(1);
        bus0.SW_RST_REQ = 1'b0;
        tick(8);
        chk0("sw2_rel0", 4'b0001, 1'b0);
        tick(2);
        bus0.SW_RST_REQ = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk0("sw2_held", 4'b0000, 1'b0);
        end
        bus0.SW_RST_REQ = 1'b0;
        tick(7);
        chk0("sw2_hold", 4'b0000, 1'b0);
        tick(1);
        chk0("sw2_rel0b", 4'b0001, 1'b0);
        tick(16);
        chk0("sw2_rel1", 4'b0011, 1'b0);
        tick(5);
        chk0("pre_pulse", 4'b0011, 1'b0);

        #2 ARSTN = 1'b0;
        #1;
        chk0("arst_async", 4'b0000, 1'b0);
        #2 ARSTN = 1'b1;
        run_seq("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Orders the release of NUM_STAGES downstream reset domains that share one clock, e.g. FIFO pointer logic first and then the read/write client logic.
- Synchronises the async board reset internally, holds all domains in reset for a minimum time, then releases them one at a time with a fixed spacing.
- Supports a synchronous software-requested re-sequence.
- Sits between the board reset pin and every per-domain reset input in the clock domain.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; must be >= 1.
- HOLD_CYCLES, 8: minimum cycles all stages stay asserted after the internal reset clears or SW_RST_REQ drops; must be >= 1.
- STAGE_DELAY, 16: cycles between consecutive stage releases; must be >= 1.

Ports:
- CLK  input  1  single clock for the block and all sequenced domains.
- ARSTN  input  1  asynchronous, active-low reset.
- SW_RST_REQ  input  1  synchronous, active-high level; re-runs the sequence.
- STAGE_RSTN  output  NUM_STAGES  active-low resets; bit 0 is released first.
- RST_DONE  output  1  high once every stage is released.
- BUSY  output  1  high whenever RST_DONE is low.

Behaviour:
- ARSTN low, at any time including mid-sequence: STAGE_RSTN = all 0, RST_DONE = 0, BUSY = 1, immediately and asynchronously. FSM goes to ASSERT and counters clear.
- Internal reset: ARSTN passes through a 2-flop synchroniser (srstn). All FSM, counter and output flops are async-cleared by ARSTN and treated as held while srstn = 0.
- Edge numbering: E1 is the first CLK rising edge with ARSTN high. srstn goes high after E2, so E3 is the first edge on which the FSM counts.
- FSM states: ASSERT, RELEASE, DONE (enum in the package).
- ASSERT:
  - All STAGE_RSTN = 0.
  - hold_cnt increments each edge while SW_RST_REQ = 0. It is forced to 0 on any edge where SW_RST_REQ = 1.
  - On the edge where hold_cnt == HOLD_CYCLES-1: set STAGE_RSTN[0] = 1, set stage_idx = 0, clear dly_cnt, go to RELEASE.
  - After ARSTN, STAGE_RSTN[0] rises after edge E(2+HOLD_CYCLES).
- RELEASE:
  - dly_cnt increments each edge.
  - On the edge where dly_cnt == STAGE_DELAY-1: release STAGE_RSTN[stage_idx+1], increment stage_idx, clear dly_cnt.
  - If stage_idx == NUM_STAGES-1 at the moment dly_cnt would start, go to DONE on the next edge and set RST_DONE = 1 on that edge.
  - Net timing: STAGE_RSTN[k] rises at release0 + k*STAGE_DELAY edges; RST_DONE rises 1 edge after the last stage.
  - NUM_STAGES = 1: RST_DONE rises 1 edge after STAGE_RSTN[0].
- DONE: outputs stay static; RST_DONE = 1, BUSY = 0.
- SW_RST_REQ = 1 sampled in RELEASE or DONE:
  - On that edge, all STAGE_RSTN = 0 together, RST_DONE = 0, go to ASSERT with hold_cnt = 0.
  - While the request is held high, ASSERT does not count.
  - Release of stage 0 happens HOLD_CYCLES edges after the first edge that samples SW_RST_REQ = 0.
- Monotonic release: released stages never re-assert except all together (ARSTN or SW_RST_REQ). STAGE_RSTN[k] = 1 always implies STAGE_RSTN[k-1] = 1.
- Output timing: all outputs are registered; no combinational path from inputs to outputs.
- Counter widths: hold_cnt is $clog2(HOLD_CYCLES+1) bits; dly_cnt is $clog2(STAGE_DELAY+1) bits; stage_idx is $clog2(NUM_STAGES+1) bits. Counters saturate by construction and never wrap.
- Parameter checks: illegal parameter values (< 1) stop elaboration with a $error.

Decomposition:
- Package reset_seq_pkg:
  - reset_seq_state_t enum {ASSERT, RELEASE, DONE}.
  - Function for counter width, returning $clog2(x+1).
- One sub-module: sync_reset, the existing 2-flop async-assert/sync-release synchroniser. Instance it for ARSTN -> srstn; do not duplicate it inline.

Test Plan (defaults N=4, HOLD=8, DELAY=16):
- Power-up: ARSTN low 5 cycles, then high -> STAGE_RSTN = 0000 until E10; 0001 after E10, 0011 after E26, 0111 after E42, 1111 after E58; RST_DONE and BUSY = 0 rise/fall after E59.
- ARSTN pulsed low for 3 ns between edges while stage 2 is pending (STAGE_RSTN = 0011) -> STAGE_RSTN = 0000 and RST_DONE = 0 asynchronously; sequence restarts with identical timing from the new E1.
- SW_RST_REQ high 1 cycle in DONE -> all outputs low on the sampling edge; STAGE_RSTN[0] = 1 8 edges after the first edge sampling the request low; RST_DONE returns 49 edges after that.
- SW_RST_REQ held 20 cycles during RELEASE (STAGE_RSTN = 0001) -> 0000 for the whole hold plus 8 cycles, then the full ordering repeats.
- Parameter sweep N=1, HOLD=1, DELAY=1 -> STAGE_RSTN[0] after E3, RST_DONE after E4. Assertion throughout all runs: monotonic-release property; BUSY == !RST_DONE.
